// File: rtl/branch_predictor_btb_if.sv
// Bus between the IF/ID stages and the branch target buffer: lookup port,
// resolved-branch update port, pipeline controls and statistics.
interface branch_predictor_btb_if #(
    parameter int WORD_LEN = 32,
    parameter int STAT_W   = 16
);
    logic                freeze;
    logic                flush_all;
    logic [WORD_LEN-1:0] lookup_pc;
    logic                pred_hit;
    logic                pred_taken;
    logic [WORD_LEN-1:0] pred_target;
    // upd_valid qualifies the upd_* fields for one cycle; there is no ready.
    // The update is taken at the clk edge unless freeze, flush_all or rst is
    // high, in which case it is dropped and the source must present it again.
    logic                upd_valid;
    logic [WORD_LEN-1:0] upd_pc;
    logic                upd_taken;
    logic [WORD_LEN-1:0] upd_target;
    logic                upd_pred_taken;
    logic [WORD_LEN-1:0] upd_pred_target;
    logic                mispredict;
    logic [WORD_LEN-1:0] redirect_pc;
    logic [STAT_W-1:0]   stat_branches;
    logic [STAT_W-1:0]   stat_mispredicts;

    modport master (
        output freeze, flush_all, lookup_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  freeze, flush_all, lookup_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
        output stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters:
// combinational IF lookup, ID-stage update with mispredict/redirect and stats.
module branch_predictor_btb #(
    parameter int WORD_LEN = 32,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 2,
    parameter int ADDR_LSB = 2,
    parameter int PC_INC   = 4,
    parameter int STAT_W   = 16
) (
    input logic clk,
    input logic rst,
    branch_predictor_btb_if.slave bus
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = WORD_LEN - ADDR_LSB - IDX_W;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [WORD_LEN-1:0] target_q [ENTRIES];
    logic [CNT_W-1:0]    cnt_q    [ENTRIES];
    logic [STAT_W-1:0]   stat_br_q;
    logic [STAT_W-1:0]   stat_mp_q;

    logic [IDX_W-1:0]    lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [IDX_W-1:0]    up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic                lk_hit;
    logic                lk_taken;
    logic                up_hit;
    logic                accept;
    logic [WORD_LEN-1:0] actual_next;
    logic                mispredict;

    assign lk_idx   = bus.lookup_pc[ADDR_LSB+IDX_W-1:ADDR_LSB];
    assign lk_tag   = bus.lookup_pc[WORD_LEN-1:ADDR_LSB+IDX_W];
    assign up_idx   = bus.upd_pc[ADDR_LSB+IDX_W-1:ADDR_LSB];
    assign up_tag   = bus.upd_pc[WORD_LEN-1:ADDR_LSB+IDX_W];

    // Lookup reads registered state only, so an update is seen a cycle later.
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_taken ? target_q[lk_idx]
                                      : bus.lookup_pc + WORD_LEN'(PC_INC);

    assign actual_next = bus.upd_taken ? bus.upd_target
                                       : bus.upd_pc + WORD_LEN'(PC_INC);
    // The upd_pred_taken bit is implied by upd_pred_target; only the
    // predicted next PC decides whether fetch went the wrong way.
    assign mispredict  = bus.upd_valid && !bus.freeze
                         && (bus.upd_pred_target != actual_next);
    assign accept      = bus.upd_valid && !bus.freeze && !bus.flush_all && !rst;

    assign bus.mispredict       = mispredict;
    assign bus.redirect_pc      = actual_next;
    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (bus.flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
        end else if (accept) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    if (cnt_q[up_idx] != CNT_MAX) cnt_q[up_idx] <= cnt_q[up_idx] + CNT_W'(1);
                    target_q[up_idx] <= bus.upd_target;
                end else if (cnt_q[up_idx] != '0) begin
                    cnt_q[up_idx] <= cnt_q[up_idx] - CNT_W'(1);
                end
            end else if (bus.upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bus.upd_target;
                cnt_q[up_idx]    <= CNT_WT;
            end
            if (stat_br_q != '1) stat_br_q <= stat_br_q + STAT_W'(1);
            if (mispredict && stat_mp_q != '1) stat_mp_q <= stat_mp_q + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed scenarios plus randomized traffic
// checked against an array-based model of the prediction tables.
module tb_branch_predictor_btb;
  localparam int STAT_MAX = 15;

  logic clk = 1'b0;
  logic rst;
  int tests_run = 0;
  int tests_failed = 0;

  branch_predictor_btb_if #(.WORD_LEN(32), .STAT_W(4)) bus ();

  branch_predictor_btb #(
    .WORD_LEN(32), .IDX_W(4), .CNT_W(2), .ADDR_LSB(2), .PC_INC(4), .STAT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: one record per index, counter as a plain integer 0..3.
  bit          m_valid [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_target [16];
  int          m_cnt [16];
  int          m_br;
  int          m_mp;

  function automatic int m_index(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == (pc / 64));
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_cnt[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred(logic [31:0] pc);
    logic [31:0] seq;
    seq = pc + 32'd4;
    return m_taken(pc) ? m_target[m_index(pc)] : seq;
  endfunction

  function automatic logic [31:0] m_actual();
    logic [31:0] seq;
    seq = bus.upd_pc + 32'd4;
    return bus.upd_taken ? bus.upd_target : seq;
  endfunction

  function automatic bit m_mispredict();
    return bus.upd_valid && !bus.freeze && (bus.upd_pred_target != m_actual());
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i] = 1;
    end
  endtask

  task automatic m_apply();
    int i;
    if (rst) begin
      m_clear();
      m_br = 0;
      m_mp = 0;
    end else if (bus.flush_all) begin
      m_clear();
    end else if (bus.upd_valid && !bus.freeze) begin
      i = m_index(bus.upd_pc);
      if (m_mispredict() && m_mp < STAT_MAX) m_mp++;
      if (m_br < STAT_MAX) m_br++;
      if (m_hit(bus.upd_pc)) begin
        if (bus.upd_taken) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_target[i] = bus.upd_target;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (bus.upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i] = bus.upd_pc / 64;
        m_target[i] = bus.upd_target;
        m_cnt[i] = 2;
      end
    end
  endtask

  // Advance one clock: model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    m_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [31:0] ptgt);
    bus.upd_valid = v;
    bus.upd_pc = pc;
    bus.upd_taken = tk;
    bus.upd_target = tgt;
    bus.upd_pred_target = ptgt;
    bus.upd_pred_taken = (ptgt != pc + 32'd4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.freeze = 1'b0;
    bus.flush_all = 1'b0;
    bus.lookup_pc = 32'h40;
    set_upd(1'b0, 32'h1234, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b0 || bus.pred_taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pred hit=%0b taken=%0b required 0 0", bus.pred_hit, bus.pred_taken);
    end
    tests_run++;
    if (bus.pred_target !== 32'h44) begin
      tests_failed++;
      $display("FAIL reset_target got %h required 00000044", bus.pred_target);
    end
    tests_run++;
    if (bus.mispredict !== 1'b0 || bus.redirect_pc !== 32'h1238) begin
      tests_failed++;
      $display("FAIL reset_redirect mp=%0b pc=%h required 0 00001238", bus.mispredict, bus.redirect_pc);
    end
    tests_run++;
    if (bus.stat_branches !== 4'd0 || bus.stat_mispredicts !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_stats br=%0d mp=%0d required 0 0", bus.stat_branches, bus.stat_mispredicts);
    end
    bus.lookup_pc = 32'hFFFF_FFFC;
    set_upd(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    #1;
    tests_run++;
    if (bus.pred_target !== 32'h0 || bus.redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL pc_wrap target=%h redirect=%h required 0 0", bus.pred_target, bus.redirect_pc);
    end
  endtask

  task automatic test_basic();
    bus.lookup_pc = 32'h40;
    set_upd(1'b1, 32'h40, 1'b1, 32'h100, 32'h44);
    #1;
    tests_run++;
    if (bus.mispredict !== 1'b1 || bus.redirect_pc !== 32'h100) begin
      tests_failed++;
      $display("FAIL basic_mispredict mp=%0b pc=%h required 1 00000100", bus.mispredict, bus.redirect_pc);
    end
    tick();
    set_upd(1'b0, 32'h40, 1'b0, 32'h0, 32'h44);
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h100) begin
      tests_failed++;
      $display("FAIL basic_lookup hit=%0b taken=%0b tgt=%h required 1 1 00000100",
               bus.pred_hit, bus.pred_taken, bus.pred_target);
    end
    tests_run++;
    if (bus.stat_branches !== 4'd1 || bus.stat_mispredicts !== 4'd1) begin
      tests_failed++;
      $display("FAIL basic_stats br=%0d mp=%0d required 1 1", bus.stat_branches, bus.stat_mispredicts);
    end
  endtask

  task automatic test_alias();
    bus.lookup_pc = 32'h80;
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b0 || bus.pred_target !== 32'h84) begin
      tests_failed++;
      $display("FAIL alias_miss hit=%0b tgt=%h required 0 00000084", bus.pred_hit, bus.pred_target);
    end
    set_upd(1'b1, 32'h80, 1'b1, 32'h200, 32'h84);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    bus.lookup_pc = 32'h40;
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b0 || bus.pred_target !== 32'h44) begin
      tests_failed++;
      $display("FAIL alias_evict hit=%0b tgt=%h required 0 00000044", bus.pred_hit, bus.pred_target);
    end
  endtask

  task automatic test_saturation();
    bus.lookup_pc = 32'h40;
    set_upd(1'b1, 32'h40, 1'b1, 32'h100, 32'h44);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_upd(1'b1, 32'h40, 1'b1, 32'h100, 32'h100);
      #1;
      tests_run++;
      if (bus.mispredict !== 1'b0) begin
        tests_failed++;
        $display("FAIL sat_taken_%0d mp=%0b required 0", k, bus.mispredict);
      end
      tick();
    end
    set_upd(1'b1, 32'h40, 1'b0, 32'h100, 32'h100);
    #1;
    tests_run++;
    if (bus.mispredict !== 1'b1 || bus.redirect_pc !== 32'h44) begin
      tests_failed++;
      $display("FAIL sat_nt1 mp=%0b pc=%h required 1 00000044", bus.mispredict, bus.redirect_pc);
    end
    tick();
    tests_run++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h100) begin
      tests_failed++;
      $display("FAIL sat_cnt2 taken=%0b tgt=%h required 1 00000100", bus.pred_taken, bus.pred_target);
    end
    tick();
    set_upd(1'b0, 32'h40, 1'b0, 32'h0, 32'h44);
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b1 || bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h44) begin
      tests_failed++;
      $display("FAIL sat_cnt1 hit=%0b taken=%0b tgt=%h required 1 0 00000044",
               bus.pred_hit, bus.pred_taken, bus.pred_target);
    end
  endtask

  task automatic test_freeze();
    int br0;
    int mp0;
    br0 = m_br;
    mp0 = m_mp;
    bus.lookup_pc = 32'h300;
    bus.freeze = 1'b1;
    set_upd(1'b1, 32'h300, 1'b1, 32'h500, 32'h304);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (bus.mispredict !== 1'b0) begin
        tests_failed++;
        $display("FAIL freeze_mp_%0d got %0b required 0", k, bus.mispredict);
      end
      tick();
    end
    tests_run++;
    if (bus.pred_hit !== 1'b0 || bus.stat_branches !== 4'(br0) || bus.stat_mispredicts !== 4'(mp0)) begin
      tests_failed++;
      $display("FAIL freeze_hold hit=%0b br=%0d mp=%0d required 0 %0d %0d",
               bus.pred_hit, bus.stat_branches, bus.stat_mispredicts, br0, mp0);
    end
    bus.freeze = 1'b0;
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b1 || bus.pred_target !== 32'h500
        || bus.stat_branches !== 4'(br0 + 1) || bus.stat_mispredicts !== 4'(mp0 + 1)) begin
      tests_failed++;
      $display("FAIL freeze_release hit=%0b tgt=%h br=%0d mp=%0d required 1 00000500 %0d %0d",
               bus.pred_hit, bus.pred_target, bus.stat_branches, bus.stat_mispredicts, br0 + 1, mp0 + 1);
    end
  endtask

  task automatic test_same_cycle();
    int br0;
    bus.flush_all = 1'b1;
    tick();
    bus.flush_all = 1'b0;
    bus.lookup_pc = 32'h40;
    set_upd(1'b1, 32'h40, 1'b1, 32'h140, 32'h44);
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_old got hit=%0b required 0", bus.pred_hit);
    end
    tick();
    tests_run++;
    if (bus.pred_hit !== 1'b1 || bus.pred_target !== 32'h140) begin
      tests_failed++;
      $display("FAIL same_cycle_new hit=%0b tgt=%h required 1 00000140", bus.pred_hit, bus.pred_target);
    end
    br0 = m_br;
    bus.flush_all = 1'b1;
    set_upd(1'b1, 32'h48, 1'b1, 32'h240, 32'h4C);
    tick();
    bus.flush_all = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b0 || bus.stat_branches !== 4'(br0)) begin
      tests_failed++;
      $display("FAIL flush_0x40 hit=%0b br=%0d required 0 %0d", bus.pred_hit, bus.stat_branches, br0);
    end
    bus.lookup_pc = 32'h48;
    #1;
    tests_run++;
    if (bus.pred_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop hit=%0b required 0", bus.pred_hit);
    end
  endtask

  task automatic test_stat_saturation();
    logic [31:0] pc;
    logic [31:0] tgt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pc = {$urandom_range(0, 255), 2'b00};
      tgt = {$urandom_range(0, 255), 2'b00};
      bus.lookup_pc = pc;
      set_upd(1'b1, pc, 1'b1, tgt, tgt + 32'd4);
      #1;
      tests_run++;
      if (bus.mispredict !== 1'b1 || bus.redirect_pc !== tgt) begin
        tests_failed++;
        $display("FAIL stat_mp_%0d mp=%0b pc=%h required 1 %h", k, bus.mispredict, bus.redirect_pc, tgt);
      end
      tick();
    end
    tests_run++;
    if (bus.stat_branches !== 4'd15 || bus.stat_mispredicts !== 4'd15) begin
      tests_failed++;
      $display("FAIL stat_saturate br=%0d mp=%0d required 15 15", bus.stat_branches, bus.stat_mispredicts);
    end
    bus.lookup_pc = pc;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    #1;
    tests_run++;
    if (bus.stat_branches !== 4'd0 || bus.stat_mispredicts !== 4'd0 || bus.pred_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL stat_rst br=%0d mp=%0d hit=%0b required 0 0 0",
               bus.stat_branches, bus.stat_mispredicts, bus.pred_hit);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] ptgt;
    int errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      bus.lookup_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      tgt = {$urandom_range(0, 1023), 2'b00};
      ptgt = ($urandom_range(0, 3) != 0) ? m_pred(pc) : {$urandom_range(0, 1023), 2'b00};
      set_upd($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1, tgt, ptgt);
      bus.freeze = ($urandom_range(0, 7) == 0);
      bus.flush_all = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      tests_run++;
      if (bus.pred_hit !== m_hit(bus.lookup_pc) || bus.pred_taken !== m_taken(bus.lookup_pc)
          || bus.pred_target !== m_pred(bus.lookup_pc) || bus.mispredict !== m_mispredict()
          || bus.redirect_pc !== m_actual() || bus.stat_branches !== 4'(m_br)
          || bus.stat_mispredicts !== 4'(m_mp)) begin
        tests_failed++;
        errs++;
        if (errs <= 5)
          $display("FAIL random_%0d hit=%0b/%0b taken=%0b/%0b tgt=%h/%h mp=%0b/%0b rd=%h/%h br=%0d/%0d mps=%0d/%0d",
                   k, bus.pred_hit, m_hit(bus.lookup_pc), bus.pred_taken, m_taken(bus.lookup_pc),
                   bus.pred_target, m_pred(bus.lookup_pc), bus.mispredict, m_mispredict(),
                   bus.redirect_pc, m_actual(), bus.stat_branches, m_br, bus.stat_mispredicts, m_mp);
      end
      tick();
    end
    rst = 1'b0;
    bus.freeze = 1'b0;
    bus.flush_all = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alias();
    test_saturation();
    test_freeze();
    test_same_cycle();
    test_stat_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters, sitting beside the IF stage of the 5-stage pipelined CPU.
- IF looks up the current PC combinationally and gets a predicted next PC.
- ID reports each resolved branch. The block updates its tables, flags mispredictions and supplies the redirect PC.
- Replaces the current "flush IF on every taken branch" behaviour with prediction, so correctly predicted taken branches cost zero bubbles.

Parameters:
- WORD_LEN, 32, PC/target width.
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W.
- CNT_W, 2, direction counter width (>=1).
- ADDR_LSB, 2, PC bits below the index (word-aligned fetch).
- PC_INC, 4, sequential PC increment.
- STAT_W, 16, statistics counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- freeze  in  1  hazard stall; blocks update acceptance.
- flush_all  in  1  synchronous invalidate of the whole table.
- lookup_pc  in  WORD_LEN  IF-stage PC.
- pred_hit  out  1  lookup_pc hits a valid entry.
- pred_taken  out  1  predicted taken.
- pred_target  out  WORD_LEN  predicted next PC.
- upd_valid  in  1  ID holds a resolved branch.
- upd_pc  in  WORD_LEN  PC of that branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  WORD_LEN  actual taken target.
- upd_pred_taken  in  1  prediction carried through IF2ID.
- upd_pred_target  in  WORD_LEN  predicted next PC carried through IF2ID.
- mispredict  out  1  flush IF/ID and redirect.
- redirect_pc  out  WORD_LEN  correct next PC.
- stat_branches  out  STAT_W  accepted updates.
- stat_mispredicts  out  STAT_W  accepted mispredicts.

Behaviour:
- Only clk is a clock. rst is synchronous active-high and has priority over flush_all, which has priority over an update.
- Field slicing:
  - idx(pc) = pc[ADDR_LSB+IDX_W-1:ADDR_LSB].
  - tag(pc) = pc[WORD_LEN-1:ADDR_LSB+IDX_W].
- Per-entry state: valid, tag, target, cnt[CNT_W].
- Reset and flush_all: every valid=0, every cnt=WNT (2**(CNT_W-1)-1). Reset also clears both stats to 0.
- Lookup is combinational from state and lookup_pc:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & cnt[MSB].
  - pred_target = pred_taken ? target : lookup_pc+PC_INC.
- Output values after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+PC_INC, mispredict=0 (given upd_valid=0), redirect_pc=upd_pc+PC_INC.
- Acceptance: accept = upd_valid & ~freeze & ~flush_all & ~rst. All state changes happen at the clk edge.
- Update on hit at idx(upd_pc): cnt saturating +1 if taken, saturating -1 if not taken. If taken, overwrite target with upd_target.
- Update on miss:
  - Taken: allocate (overwriting any alias): valid=1, tag, target=upd_target, cnt=WT (2**(CNT_W-1)).
  - Not taken: no change.
- Correct next PC: actual_next = upd_taken ? upd_target : upd_pc+PC_INC.
- Mispredict: mispredict = upd_valid & ~freeze & (upd_pred_target != actual_next). It is combinational, valid in the same cycle as the update. redirect_pc = actual_next, also combinational.
- Latency:
  - Lookup is 0 cycles.
  - An update is visible to lookups from the next cycle. There is no same-cycle write-to-read bypass; a same-index lookup in the update cycle sees the old state.
- Stats: on accept, stat_branches+=1 and, on mispredict, stat_mispredicts+=1. Both saturate at all-ones and never wrap.
- Arithmetic: PC+PC_INC wraps modulo 2**WORD_LEN.
- Boundary cases:
  - freeze held N cycles with upd_valid=1: zero updates, zero stat increments.
  - rst mid-stream: next cycle the table is empty and stats are 0.

Test Plan:
- Reset, lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44. Update upd_pc=0x40, taken, target 0x100, pred_target=0x44 -> mispredict=1, redirect_pc=0x100. Next cycle lookup 0x40 -> hit, taken, pred_target=0x100. stat_branches=1, stat_mispredicts=1.
- Alias: after the previous case, lookup 0x80 (same idx 0, different tag) -> pred_hit=0, pred_target=0x84. Taken update 0x80 -> 0x200 -> lookup 0x40 now misses.
- Counter saturation on 0x40:
  - 3 taken updates with correct predictions -> cnt=3, mispredict=0 each time.
  - Then 1 not-taken -> mispredict=1, redirect 0x44; pred_taken stays 1 (cnt=2).
  - Second not-taken -> cnt=1, pred_taken=0.
- freeze=1 with upd_valid=1, taken, for 3 cycles -> table and stats unchanged, mispredict=0. Release freeze -> exactly one update applied.
- Same-cycle lookup and update of 0x40 (untrained) -> lookup shows miss that cycle, hit the next. Then flush_all together with an update -> table cleared, update dropped.
- STAT_W=4: 20 consecutive accepted mispredicts -> stat_mispredicts=15, stat_branches=15. Assert rst mid-sequence -> both 0 next cycle.
